// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 scan-code sequencer.
// Holds set-2 prefix bytes, key codes, direction/state enums and the event struct.
package kbd_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_A = 8'h1C;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_SKIP    = 3'd4
    } pstate_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

    // Opposite directions differ only in bit 1.
    function automatic logic is_reverse(dir_t a, dir_t b);
        return (a ^ b) == 2'd2;
    endfunction

endpackage

// File: rtl/ps2_scan_sequencer_if.sv
// Receiver-side and consumer-side signals of the scan sequencer.
// master drives bytes and pops; slave is the sequencer.
interface ps2_scan_sequencer_if;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic       read;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [1:0] dir;
    logic       overflow;

    modport master (
        output scan_ready, scan_code, evt_ready,
        input  read, evt_valid, evt_code, evt_ext, evt_break, dir, overflow
    );

    modport slave (
        input  scan_ready, scan_code, evt_ready,
        output read, evt_valid, evt_code, evt_ext, evt_break, dir, overflow
    );
endinterface

// File: rtl/kbd_evt_fifo.sv
// Synchronous event FIFO with wrap-bit pointers and same-cycle push/pop.
// When empty the head output holds the last popped entry.
import kbd_pkg::*;

module kbd_evt_fifo #(
    parameter int DEPTH = 4
) (
    input  logic     clock50,
    input  logic     reset,
    input  logic     push_i,
    input  kbd_evt_t data_i,
    input  logic     pop_i,
    output kbd_evt_t head_o,
    output logic     valid_o,
    output logic     full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, rd_q;
    kbd_evt_t    mem_q [DEPTH];
    kbd_evt_t    last_q;
    logic        empty, do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full_o | do_pop);
    assign valid_o = ~empty;
    assign head_o  = empty ? last_q : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clock50) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) begin
                rd_q   <= rd_q + 1'b1;
                last_q <= mem_q[rd_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clock50) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 set-2 scan sequencer: read handshake, prefix parser, event FIFO, direction latch.
// Define KBD_WASD_EN to let non-extended WASD make codes steer the direction too.
import kbd_pkg::*;

module ps2_scan_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clock50,
    input logic                 reset,
    ps2_scan_sequencer_if.slave bus
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q, read_q, rise;
    logic [7:0]             code_q;
    pstate_t                state_q, state_d;
    logic [2:0]             skip_q, skip_d;
    dir_t                   dir_q, dir_d, req;
    logic                   req_v, emit, overflow_q;
    kbd_evt_t               evt, head;
    logic                   fifo_full, fifo_valid, pop;

    assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign pop  = fifo_valid & bus.evt_ready;

    always_ff @(posedge clock50) begin
        if (reset) begin
            sync_q     <= '0;
            edge_q     <= 1'b0;
            read_q     <= 1'b0;
            code_q     <= '0;
            state_q    <= S_IDLE;
            skip_q     <= '0;
            dir_q      <= UP;
            overflow_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.scan_ready};
            edge_q  <= sync_q[SYNC_STAGES-1];
            read_q  <= rise;
            if (rise) code_q <= bus.scan_code;
            state_q <= state_d;
            skip_q  <= skip_d;
            dir_q   <= dir_d;
            if (emit && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (read_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (code_q == PS2_EXT) state_d = S_EXT;
                    else if (code_q == PS2_BRK) state_d = S_BRK;
                    else if (code_q == PS2_PAUSE) begin
                        state_d = S_SKIP;
                        skip_d  = 3'd7;
                    end
                end
                S_EXT: begin
                    if (code_q == PS2_BRK) state_d = S_EXT_BRK;
                    else if (code_q != PS2_EXT) state_d = S_IDLE;
                end
                S_BRK:     state_d = S_IDLE;
                S_EXT_BRK: state_d = S_IDLE;
                S_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        emit     = 1'b0;
        evt.code = code_q;
        evt.ext  = 1'b0;
        evt.brk  = 1'b0;
        if (read_q) begin
            unique case (state_q)
                S_IDLE: emit = !(code_q inside
                    {PS2_EXT, PS2_BRK, PS2_PAUSE, PS2_BAT, PS2_ACK});
                S_EXT: begin
                    emit    = (code_q != PS2_EXT) && (code_q != PS2_BRK);
                    evt.ext = 1'b1;
                end
                S_BRK: begin
                    emit    = (code_q != PS2_EXT) && (code_q != PS2_BRK);
                    evt.brk = 1'b1;
                end
                S_EXT_BRK: begin
                    emit    = 1'b1;
                    evt.ext = 1'b1;
                    evt.brk = 1'b1;
                end
                default: emit = 1'b0;
            endcase
        end
    end

    always_comb begin
        req_v = 1'b0;
        req   = UP;
        if (emit && !evt.brk && evt.ext) begin
            req_v = 1'b1;
            unique case (evt.code)
                KEY_UP:    req = UP;
                KEY_RIGHT: req = RIGHT;
                KEY_DOWN:  req = DOWN;
                KEY_LEFT:  req = LEFT;
                default:   req_v = 1'b0;
            endcase
        end
`ifdef KBD_WASD_EN
        else if (emit && !evt.brk) begin
            req_v = 1'b1;
            unique case (evt.code)
                KEY_W:   req = UP;
                KEY_D:   req = RIGHT;
                KEY_S:   req = DOWN;
                KEY_A:   req = LEFT;
                default: req_v = 1'b0;
            endcase
        end
`endif
        dir_d = dir_q;
        if (req_v && !is_reverse(req, dir_q)) dir_d = req;
    end

    kbd_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock50 (clock50),
        .reset   (reset),
        .push_i  (emit),
        .data_i  (evt),
        .pop_i   (pop),
        .head_o  (head),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

    assign bus.read      = read_q;
    assign bus.evt_valid = fifo_valid;
    assign bus.evt_code  = head.code;
    assign bus.evt_ext   = head.ext;
    assign bus.evt_break = head.brk;
    assign bus.dir       = dir_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Scoreboard bench for ps2_scan_sequencer: receiver model drives bytes,
// expected events are queued on send and compared on every pop.
module tb_ps2_scan_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_read = 0;
    int   t_read = -1;
    int   t_valid = -1;
    logic prev_read = 1'b0;
    logic [9:0] sb [$];

    ps2_scan_sequencer_if bus ();

    ps2_scan_sequencer dut (
        .clock50 (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.read) begin
            n_read++;
            if (t_read < 0) t_read = cyc;
            if (prev_read) check("read_width", 2, 1);
        end
        prev_read = bus.read;
        if (bus.evt_valid && t_valid < 0) t_valid = cyc;
        if (!rst && bus.evt_valid && bus.evt_ready) begin
            if (sb.size() == 0) check("evt_extra", 1, 0);
            else check("evt", {bus.evt_ext, bus.evt_break, bus.evt_code},
                       sb.pop_front());
        end
    end

    task automatic send(input logic [7:0] b);
        bit seen;
        seen = 0;
        bus.scan_code  = b;
        bus.scan_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.read) seen = 1;
        end
        check("read_seen", 32'(seen), 1);
        bus.scan_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input logic ext, input logic brk,
                              input logic [7:0] code);
        sb.push_back({ext, brk, code});
    endtask

    task automatic check_reset_state();
        check("rst_read", 32'(bus.read), 0);
        check("rst_valid", 32'(bus.evt_valid), 0);
        check("rst_code", 32'(bus.evt_code), 0);
        check("rst_flags", {bus.evt_ext, bus.evt_break}, 0);
        check("rst_dir", 32'(bus.dir), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
    endtask

    initial begin
        int t0;
        int r0;
        logic [7:0] pause_seq [8];
        logic [7:0] fill [5];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        fill = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
        bus.scan_ready = 1'b0;
        bus.scan_code  = 8'h00;
        bus.evt_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();

        // single make byte: latency and no WASD steering
        expect_evt(0, 0, 8'h1D);
        t_read  = -1;
        t_valid = -1;
        t0 = cyc;
        r0 = n_read;
        send(8'h1D);
        check("lat_read", t_read - t0, 3);
        check("lat_valid", t_valid - t0, 4);
        check("read_cnt1", n_read - r0, 1);
        check("dir_1d", 32'(bus.dir), 0);

        // extended arrows, make and break
        expect_evt(1, 0, 8'h74);
        send(8'hE0); send(8'h74);
        check("dir_right", 32'(bus.dir), 1);
        expect_evt(1, 1, 8'h74);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("dir_brk", 32'(bus.dir), 1);

        // reversal rejected, perpendicular accepted
        expect_evt(1, 0, 8'h6B);
        send(8'hE0); send(8'h6B);
        check("dir_rev", 32'(bus.dir), 1);
        expect_evt(1, 0, 8'h72);
        send(8'hE0); send(8'h72);
        check("dir_down", 32'(bus.dir), 2);

        // pause sequence emits nothing
        r0 = n_read;
        foreach (pause_seq[i]) send(pause_seq[i]);
        check("pause_reads", n_read - r0, 8);
        check("pause_sb", sb.size(), 0);
        expect_evt(0, 0, 8'h29);
        send(8'h29);
        check("after_pause", sb.size(), 0);

        // overflow with consumer stalled
        bus.evt_ready = 1'b0;
        foreach (fill[i]) begin
            if (i < 4) expect_evt(0, 0, fill[i]);
            send(fill[i]);
        end
        check("ovf_set", 32'(bus.overflow), 1);
        check("ovf_valid", 32'(bus.evt_valid), 1);
        bus.evt_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("drain_sb", sb.size(), 0);
        check("drain_valid", 32'(bus.evt_valid), 0);
        check("hold_code", 32'(bus.evt_code), 32'h26);
        check("ovf_sticky", 32'(bus.overflow), 1);

        // reset mid-sequence clears prefix state
        send(8'hE0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();
        expect_evt(0, 0, 8'h75);
        send(8'h75);
        check("post_rst_dir", 32'(bus.dir), 0);
        check("post_rst_ovf", 32'(bus.overflow), 0);
        check("final_sb", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
- Sits between the PS/2 byte receiver (`scan_ready` / `scan_code` / `read`) and game logic.
- Owns the receiver's read handshake: detects `scan_ready`, captures the byte and issues a one-cycle `read` pulse.
- Parses the scan-code set 2 prefixes E0, F0 and E1, and queues decoded make/break key events in a small FIFO.
- Maintains a latched snake direction from arrow-key make events; reversal is rejected.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, ≥2.
- SYNC_STAGES, 2, synchroniser flops on `scan_ready`; ≥2.

Ports:
- clock50  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-high.
- scan_ready  in  1  byte-available level from the receiver; asynchronous to clock50.
- scan_code  in  8  receiver byte; stable while `scan_ready` is high.
- read  out  1  one-cycle pulse that clears receiver `scan_ready`.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer pop; a pop occurs when `evt_valid` and `evt_ready` are both high.
- evt_code  out  8  key code of the head event.
- evt_ext  out  1  head event had an E0 prefix.
- evt_break  out  1  head event is a release (F0 prefix).
- dir  out  2  latched direction: 0=up, 1=right, 2=down, 3=left.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset: clock50 domain, synchronous, active-high.
  - All outputs are 0: `read`, `evt_valid`, `evt_code`, `evt_ext`, `evt_break`, `dir` (=up), `overflow`.
  - FIFO is emptied, the FSM goes to IDLE, the skip counter is cleared and all sync flops are cleared.
- Input capture:
  - `scan_ready` passes through SYNC_STAGES flops, then an edge register. A rising edge is `sync_out & ~edge_reg`.
  - In the edge cycle, `scan_code` is registered and `read` is driven high on the next clock for exactly 1 cycle. With the default, `read` rises on the 3rd clock after `scan_ready` rises.
  - No second `read` is issued until `scan_ready` has been seen low and then high again.
  - If `scan_ready` is already high at reset release, it is treated as a fresh edge and the byte is processed normally.
- Parser FSM: states IDLE, EXT, BRK, EXT_BRK, SKIP. Transitions are evaluated in the cycle `read` is high.
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - E1 → SKIP with skip_cnt=7.
    - Any other byte → emit {code, ext=0, brk=0}.
  - EXT:
    - F0 → EXT_BRK.
    - E0 → stay in EXT.
    - Any other byte → emit {code, 1, 0}, go to IDLE.
  - BRK: any byte except E0/F0 → emit {code, 0, 1}, go to IDLE. E0 or F0 → IDLE without emitting (malformed sequence).
  - EXT_BRK: any byte → emit {code, 1, 1}, go to IDLE.
  - SKIP: decrement skip_cnt on each byte and go to IDLE when it reaches 0. Pause sequences (E1 plus 7 bytes) emit nothing.
  - Byte AA (BAT OK) and byte FA (ACK) received in IDLE are discarded.
- Event FIFO:
  - An emit writes in the `read` cycle; `evt_valid` and the head fields are registered and visible 1 cycle later.
  - Default latency from `scan_ready` rise to `evt_valid` is 4 clocks.
  - Full with emit and no pop: the event is dropped and `overflow` is set. `overflow` is cleared only by reset.
  - Full with emit and pop in the same cycle: both are accepted; occupancy is unchanged.
  - Empty: `evt_valid`=0 and the head fields hold their last values. Pop while empty is ignored.
  - Pointers are log2(FIFO_DEPTH) bits plus 1 wrap bit and wrap modulo the depth.
- Direction latch:
  - Updates on emitted make events only (brk=0) with ext=1:
    - 75 → up.
    - 74 → right.
    - 72 → down.
    - 6B → left.
  - `dir` updates 1 cycle after `read`, independent of FIFO fullness.
  - A request equal to `dir ^ 2` (reverse) is ignored. A request equal to the current direction produces no change.

Optional Feature:
- Macro: KBD_WASD_EN.
- When defined, non-extended make events also update `dir`:
  - 1D → up.
  - 23 → right.
  - 1B → down.
  - 1C → left.
  - The same reversal rule applies.
  - The events are still queued in the FIFO.
- When undefined, only the E0 arrow codes affect `dir`.

Decomposition:
- Package `kbd_pkg` holds:
  - Byte constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA.
  - Arrow and WASD code constants.
  - Enum `dir_t` (UP, RIGHT, DOWN, LEFT).
  - Parser state enum.
  - Packed struct `kbd_evt_t` {ext, brk, code[7:0]}.
- One sub-module: `kbd_evt_fifo`, a parameterised synchronous FIFO of `kbd_evt_t` with full/empty and simultaneous push/pop support.

Test Plan:
- Byte 1D with `evt_ready`=1 → exactly one `read` pulse 3 clocks after the `scan_ready` rise; `evt_valid` 4 clocks after; evt {1D, ext=0, brk=0}; `dir` stays up (WASD disabled).
- Bytes E0, 74 → evt {74, 1, 0} and `dir`=right. Then E0, F0, 74 → evt {74, 1, 1} and `dir` stays right.
- From `dir`=right, bytes E0, 6B (left) → evt queued and `dir` stays right. Then E0, 72 → `dir`=down.
- Bytes E1 14 77 E1 F0 14 F0 77 → 8 `read` pulses, no events. A following byte 29 → evt {29, 0, 0}.
- `evt_ready`=0 and 5 make bytes with FIFO_DEPTH=4 → 4 events held, `overflow`=1. Draining yields the first 4 codes in order.
- Reset asserted after E0 is received, then byte 75 sent → evt {75, ext=0, brk=0}, `dir` stays up, `overflow`=0.
